fp_multi: RTL and testbench

Parametrised, fully pipelined IEEE-754-style floating-point multiplier. It is the successor to the fixed binary16 multiplier, generalised to any EXP_W/MAN_W format. It adds round-to-nearest-even, NaN handling, overflow saturation to infinity, exception flags and valid/ready backpressure. It sits in the simulator datapath between operand fetch and the accumulate/writeback stage. One result per cycle when unstalled.

---
 rtl/fp_pkg.sv | 40 ++++
 rtl/fp_round_rne.sv | 25 ++
 rtl/fp_multi.sv | 185 ++++++++++++++++++
 tb/tb_fp_multi.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions and
// format helpers used by the multiplier and its rounding stage.
package fp_pkg;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

   localparam int FLAG_INVALID   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   // Helpers take widest-supported fields; callers zero-extend their own format.
   localparam int MAX_E = 16;
   localparam int MAX_M = 64;
   localparam int MAX_W = 1 + MAX_E + MAX_M;

   function automatic fp_class_e classify(input logic [MAX_E-1:0] exp,
                                          input logic [MAX_M-1:0] frac,
                                          input int               exp_w);
      logic [MAX_E-1:0] ones;
      ones = (MAX_E'(1) << exp_w) - MAX_E'(1);
      if (exp == '0)
         return ZERO;
      if (exp != ones)
         return NORM;
      return (frac == '0) ? INF : NAN;
   endfunction

   function automatic int bias(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   function automatic logic [MAX_W-1:0] qnan(input int exp_w, input int man_w);
      logic [MAX_W-1:0] q;
      q = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
      q = q | (MAX_W'(1) << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised fraction with guard/sticky; a fraction
// carry-out bumps the exponent and leaves the fraction at zero.
module fp_round_rne #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic [MAN_W-1:0]        frac,
   input  logic                    guard,
   input  logic                    sticky,
   input  logic signed [EXP_W+1:0] exp,
   output logic [MAN_W-1:0]        frac_out,
   output logic signed [EXP_W+1:0] exp_out,
   output logic                    inexact
);

   logic         inc;
   logic [MAN_W:0] sum;

   assign inc      = guard & (sticky | frac[0]);
   assign sum      = {1'b0, frac} + {{MAN_W{1'b0}}, inc};
   assign frac_out = sum[MAN_W-1:0];
   assign exp_out  = exp + $signed({{(EXP_W+1){1'b0}}, sum[MAN_W]});
   assign inexact  = guard | sticky;

endmodule

// File: rtl/fp_multi.sv
// Three-stage pipelined floating-point multiplier (unpack, normalise, round/pack)
// with flush-to-zero, RNE rounding, exception flags and a global stall.
module fp_multi
   import fp_pkg::*;
#(
   parameter  int EXP_W = 5,
   parameter  int MAN_W = 10,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk_in,
   input  logic         rst_n,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] result,
   output logic [3:0]   flags,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   localparam int EW2    = EXP_W + 2;
   localparam int PW     = 2 * MAN_W + 2;
   localparam int BIAS_I = bias(EXP_W);
   localparam logic [MAX_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
   localparam logic signed [EW2-1:0] EXP_INF = EW2'((1 << EXP_W) - 1);

   logic advance;
   logic v1, v2, v3;

   assign advance   = !v3 || out_ready;
   assign in_ready  = advance;
   assign out_valid = v3;
   assign busy      = v1 | v2 | v3;

   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        fa, fb;
   fp_class_e               cls_a, cls_b;
   logic                    sign_p;
   logic signed [EW2-1:0]   esum;
   logic [PW-1:0]           prod;
   logic                    spec_p;
   logic [W-1:0]            spec_res_p;
   logic [3:0]              spec_flags_p;

   assign ea = a[W-2 -: EXP_W];
   assign eb = b[W-2 -: EXP_W];
   assign fa = a[MAN_W-1:0];
   assign fb = b[MAN_W-1:0];

   // Special operands are resolved up front and ride the pipe beside the datapath.
   always_comb begin
      cls_a        = classify(MAX_E'(ea), MAX_M'(fa), EXP_W);
      cls_b        = classify(MAX_E'(eb), MAX_M'(fb), EXP_W);
      sign_p       = a[W-1] ^ b[W-1];
      esum         = $signed(EW2'(ea)) + $signed(EW2'(eb)) - $signed(EW2'(BIAS_I));
      prod         = PW'({1'b1, fa}) * PW'({1'b1, fb});
      spec_p       = 1'b1;
      spec_res_p   = '0;
      spec_flags_p = '0;
      if (cls_a == NAN || cls_b == NAN ||
          (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
         spec_res_p                 = QNAN;
         spec_flags_p[FLAG_INVALID] = 1'b1;
      end else if (cls_a == INF || cls_b == INF) begin
         spec_res_p = {sign_p, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (cls_a == ZERO || cls_b == ZERO) begin
         spec_res_p = {sign_p, {(W-1){1'b0}}};
      end else begin
         spec_p = 1'b0;
      end
   end

   logic                  s1_sign, s1_spec;
   logic signed [EW2-1:0] s1_exp;
   logic [PW-1:0]         s1_prod;
   logic [W-1:0]          s1_spec_res;
   logic [3:0]            s1_spec_flags;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         v1            <= 1'b0;
         s1_sign       <= 1'b0;
         s1_spec       <= 1'b0;
         s1_exp        <= '0;
         s1_prod       <= '0;
         s1_spec_res   <= '0;
         s1_spec_flags <= '0;
      end else if (advance) begin
         v1            <= in_valid;
         s1_sign       <= sign_p;
         s1_spec       <= spec_p;
         s1_exp        <= esum;
         s1_prod       <= prod;
         s1_spec_res   <= spec_res_p;
         s1_spec_flags <= spec_flags_p;
      end
   end

   logic [PW-1:0]         norm;
   logic signed [EW2-1:0] norm_exp;

   assign norm     = s1_prod[PW-1] ? s1_prod : (s1_prod << 1);
   assign norm_exp = s1_exp + $signed({{(EW2-1){1'b0}}, s1_prod[PW-1]});

   logic                  s2_sign, s2_spec, s2_guard, s2_sticky;
   logic signed [EW2-1:0] s2_exp;
   logic [MAN_W-1:0]      s2_frac;
   logic [W-1:0]          s2_spec_res;
   logic [3:0]            s2_spec_flags;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         v2            <= 1'b0;
         s2_sign       <= 1'b0;
         s2_spec       <= 1'b0;
         s2_guard      <= 1'b0;
         s2_sticky     <= 1'b0;
         s2_exp        <= '0;
         s2_frac       <= '0;
         s2_spec_res   <= '0;
         s2_spec_flags <= '0;
      end else if (advance) begin
         v2            <= v1;
         s2_sign       <= s1_sign;
         s2_spec       <= s1_spec;
         s2_guard      <= norm[PW-2-MAN_W];
         s2_sticky     <= |norm[PW-3-MAN_W:0];
         s2_exp        <= norm_exp;
         s2_frac       <= norm[PW-2 -: MAN_W];
         s2_spec_res   <= s1_spec_res;
         s2_spec_flags <= s1_spec_flags;
      end
   end

   logic [MAN_W-1:0]      r_frac;
   logic signed [EW2-1:0] r_exp;
   logic                  r_inexact;
   logic [W-1:0]          res_n;
   logic [3:0]            flags_n;

   fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
      .frac     (s2_frac),
      .guard    (s2_guard),
      .sticky   (s2_sticky),
      .exp      (s2_exp),
      .frac_out (r_frac),
      .exp_out  (r_exp),
      .inexact  (r_inexact)
   );

   // Range checks use the post-rounding exponent so a round-up into inf is caught.
   always_comb begin
      res_n                 = {s2_sign, r_exp[EXP_W-1:0], r_frac};
      flags_n               = '0;
      flags_n[FLAG_INEXACT] = r_inexact;
      if (s2_spec) begin
         res_n   = s2_spec_res;
         flags_n = s2_spec_flags;
      end else if (r_exp >= EXP_INF) begin
         res_n                   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_n[FLAG_OVERFLOW]  = 1'b1;
         flags_n[FLAG_INEXACT]   = 1'b1;
      end else if (r_exp[EW2-1] || r_exp == '0) begin
         res_n                   = {s2_sign, {(W-1){1'b0}}};
         flags_n[FLAG_UNDERFLOW] = 1'b1;
         flags_n[FLAG_INEXACT]   = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         v3     <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else if (advance) begin
         v3     <= v2;
         result <= res_n;
         flags  <= flags_n;
      end
   end

endmodule

// File: tb/tb_fp_multi.sv
// Bench for fp_multi: binary16 directed vectors through a scoreboard queue,
// stall/backpressure, mid-stream reset, plus a binary32 instance.
module tb_fp_multi;

   logic        clk_in = 1'b0;
   logic        rst_n;
   logic [15:0] a, b, result;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0]  flags;

   logic [31:0] a32, b32, result32;
   logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
   logic [3:0]  flags32;

   always #5 clk_in = ~clk_in;

   fp_multi dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .result    (result),
      .flags     (flags),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   fp_multi #(.EXP_W(8), .MAN_W(23)) dut32 (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .a         (a32),
      .b         (b32),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .result    (result32),
      .flags     (flags32),
      .out_valid (out_valid32),
      .out_ready (out_ready32),
      .busy      (busy32)
   );

   // {a, b, expected result, expected flags}
   localparam int NV = 12;
   localparam logic [51:0] VECS [NV] = '{
      {16'h3C00, 16'h3C00, 16'h3C00, 4'h0},
      {16'h3E00, 16'h3E00, 16'h4080, 4'h0},
      {16'h3C01, 16'h3C01, 16'h3C02, 4'h1},
      {16'h3C01, 16'h3E00, 16'h3E02, 4'h1},
      {16'hBC00, 16'h3C00, 16'hBC00, 4'h0},
      {16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5},
      {16'h0400, 16'h3800, 16'h0000, 4'h3},
      {16'h7C00, 16'h0000, 16'h7E00, 4'h8},
      {16'hFC00, 16'h4000, 16'hFC00, 4'h0},
      {16'h7E01, 16'h3C00, 16'h7E00, 4'h8},
      {16'h0001, 16'h3C00, 16'h0000, 4'h0},
      {16'h4000, 16'h4000, 16'h4400, 4'h0}
   };

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_out = 0;
   logic [19:0] sb [$];
   logic [19:0] head;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output side: every valid cycle is checked against the oldest outstanding op.
   always @(negedge clk_in) begin
      if (rst_n === 1'b1) begin
         chk("in_ready", in_ready, !out_valid || out_ready);
         if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
               chk("spurious_out", out_valid, 0);
            end else begin
               head = sb[0];
               chk("result", result, head[19:4]);
               chk("flags", flags, head[3:0]);
               if (out_ready) begin
                  void'(sb.pop_front());
                  n_out++;
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at the posedge+1 after the accepting edge.
   task automatic send(input int i);
      logic [51:0] v;
      int          t;
      v        = VECS[i];
      a        = v[51:36];
      b        = v[35:20];
      in_valid = 1'b1;
      t        = 0;
      @(negedge clk_in);
      while (!in_ready && t < 50) begin
         @(negedge clk_in);
         t++;
      end
      chk("accept", in_ready, 1);
      if (in_ready)
         sb.push_back(v[19:0]);
      @(posedge clk_in);
      #1;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk_in);
         t++;
      end
      chk(tag, sb.size(), 0);
      @(posedge clk_in);
      #1;
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [51:0] v;
      int          idx;
      int          out_base;

      rst_n       = 1'b0;
      a           = '0;
      b           = '0;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      a32         = '0;
      b32         = '0;
      in_valid32  = 1'b0;
      out_ready32 = 1'b1;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", flags, 0);
      chk("rst_result", result, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      @(posedge clk_in);
      #1;

      // Isolated op: valid must rise on the third edge counting the accepting one.
      send(0);
      in_valid = 1'b0;
      chk("lat_edge1", out_valid, 0);
      @(posedge clk_in);
      #1;
      chk("lat_edge2", out_valid, 0);
      @(posedge clk_in);
      #1;
      chk("lat_edge3", out_valid, 1);
      drain("lat_drain");

      for (int i = 0; i < NV; i++)
         send(i);
      in_valid = 1'b0;
      drain("stream_drain");

      // Backpressure: out_ready low for cycles 4..10 while 8 ops stream in.
      out_base = n_out;
      idx      = 0;
      for (int c = 0; c < 60 && idx < 8; c++) begin
         out_ready = !(c >= 4 && c <= 10);
         v         = VECS[idx];
         a         = v[51:36];
         b         = v[35:20];
         in_valid  = 1'b1;
         @(negedge clk_in);
         if (c == 8) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
         end
         if (in_ready) begin
            sb.push_back(v[19:0]);
            idx++;
         end
         @(posedge clk_in);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_sent", idx, 8);
      drain("bp_drain");
      chk("bp_out_count", n_out - out_base, 8);

      // Reset between edges while results are in flight.
      send(1);
      send(2);
      send(3);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_flags", flags, 0);
      sb.delete();
      @(posedge clk_in);
      @(posedge clk_in);
      #3;
      rst_n = 1'b1;
      repeat (6) @(posedge clk_in);
      #1;
      chk("arst_idle", out_valid, 0);
      send(5);
      in_valid = 1'b0;
      @(posedge clk_in);
      #1;
      chk("arst_lat_edge2", out_valid, 0);
      @(posedge clk_in);
      #1;
      chk("arst_lat_edge3", out_valid, 1);
      drain("arst_drain");

      // binary32 instance, two back-to-back ops.
      a32        = 32'h3FC00000;
      b32        = 32'h40000000;
      in_valid32 = 1'b1;
      @(negedge clk_in);
      chk("b32_in_ready", in_ready32, 1);
      @(posedge clk_in);
      #1;
      a32 = 32'h7F7FFFFF;
      b32 = 32'h40000000;
      @(posedge clk_in);
      #1;
      in_valid32 = 1'b0;
      @(posedge clk_in);
      #1;
      chk("b32_valid1", out_valid32, 1);
      chk("b32_result1", result32, 32'h40400000);
      chk("b32_flags1", flags32, 4'h0);
      @(posedge clk_in);
      #1;
      chk("b32_valid2", out_valid32, 1);
      chk("b32_result2", result32, 32'h7F800000);
      chk("b32_flags2", flags32, 4'h5);
      @(posedge clk_in);
      #1;
      chk("b32_busy", busy32, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
